// File: rtl/univ_mod_counter.sv
// Modulo-MOD up/down counter with programmable step, wrap or saturate mode,
// synchronous clear, range-checked parallel load and registered event pulses.
module univ_mod_counter #(
    parameter int unsigned N      = 4,
    parameter int unsigned MOD    = 10,
    parameter int unsigned STEP_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syn_clr,
    input  logic              load,
    input  logic              en,
    input  logic              up,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      d,
    output logic [N-1:0]      q,
    output logic              max_tick,
    output logic              min_tick,
    output logic              wrap,
    output logic              sat_hit,
    output logic              load_err
);

    // Reject parameter sets that cannot hold the range or whose step could exceed it.
    if (MOD < 2 || (N < 32 && MOD > (32'd1 << N))) begin : g_bad_mod
        $error("univ_mod_counter: MOD must satisfy 2 <= MOD <= 2**N");
    end
    if (STEP_W == 0 || STEP_W >= 32 || ((32'd1 << STEP_W) - 32'd1) >= MOD) begin : g_bad_step
        $error("univ_mod_counter: 2**STEP_W-1 must be smaller than MOD");
    end

    localparam int unsigned XW  = N + 1;
    localparam logic [N:0]   MOD_X = XW'(MOD);
    localparam logic [N-1:0] TOP   = N'(MOD - 1);

    logic [N:0]   q_x;
    logic [N:0]   step_x;
    logic [N:0]   sum_x;
    logic [N:0]   sum_wrap_x;
    logic [N:0]   diff_x;
    logic [N:0]   diff_wrap_x;
    logic [N-1:0] q_nxt;
    logic         wrap_nxt;
    logic         sat_nxt;
    logic         lerr_nxt;

    // Widen by one bit so the up-sum and the down-wrap never overflow.
    assign q_x         = {1'b0, q};
    assign step_x      = XW'(step);
    assign sum_x       = q_x + step_x;
    assign sum_wrap_x  = sum_x - MOD_X;
    assign diff_x      = q_x - step_x;
    assign diff_wrap_x = q_x + MOD_X - step_x;

    // Next-state and pulse selection, priority clear > load > enable > hold.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        lerr_nxt = 1'b0;
        if (syn_clr) begin
            q_nxt = '0;
        end else if (load) begin
            if (d <= TOP) begin
                q_nxt = d;
            end else begin
                q_nxt    = TOP;
                lerr_nxt = 1'b1;
            end
        end else if (en && (step != '0)) begin
            if (up) begin
                if (sum_x <= {1'b0, TOP}) begin
                    q_nxt = sum_x[N-1:0];
                end else if (sat) begin
                    q_nxt   = TOP;
                    sat_nxt = 1'b1;
                end else begin
                    q_nxt    = sum_wrap_x[N-1:0];
                    wrap_nxt = 1'b1;
                end
            end else begin
                if (q_x >= step_x) begin
                    q_nxt = diff_x[N-1:0];
                end else if (sat) begin
                    q_nxt   = '0;
                    sat_nxt = 1'b1;
                end else begin
                    q_nxt    = diff_wrap_x[N-1:0];
                    wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            wrap     <= 1'b0;
            sat_hit  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_nxt;
            wrap     <= wrap_nxt;
            sat_hit  <= sat_nxt;
            load_err <= lerr_nxt;
        end
    end

    // Bound flags decode the registered count directly.
    assign max_tick = (q == TOP);
    assign min_tick = (q == '0);

endmodule

// File: tb/tb_univ_mod_counter.sv
// Self-checking bench for univ_mod_counter: directed scenarios plus a randomized
// run against an integer-arithmetic reference model.
`timescale 1ns/100ps
module tb_univ_mod_counter;

    localparam int unsigned N      = 4;
    localparam int unsigned MOD    = 10;
    localparam int unsigned STEP_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              syn_clr;
    logic              load;
    logic              en;
    logic              up;
    logic              sat;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      d;
    logic [N-1:0]      q;
    logic              max_tick;
    logic              min_tick;
    logic              wrap;
    logic              sat_hit;
    logic              load_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int   m_q;
    logic m_w;
    logic m_s;
    logic m_l;

    always #5 clk = ~clk;

    univ_mod_counter #(.N(N), .MOD(MOD), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n), .syn_clr(syn_clr), .load(load), .en(en),
        .up(up), .sat(sat), .step(step), .d(d), .q(q), .max_tick(max_tick),
        .min_tick(min_tick), .wrap(wrap), .sat_hit(sat_hit), .load_err(load_err)
    );

    task automatic model_reset();
        m_q = 0; m_w = 1'b0; m_s = 1'b0; m_l = 1'b0;
    endtask

    // Apply one clock edge to the model using plain modular arithmetic.
    task automatic model_edge();
        int s;
        m_w = 1'b0; m_s = 1'b0; m_l = 1'b0;
        if (syn_clr) begin
            m_q = 0;
        end else if (load) begin
            if (int'(d) < int'(MOD)) m_q = int'(d);
            else begin m_q = MOD - 1; m_l = 1'b1; end
        end else if (en && int'(step) != 0) begin
            s = up ? m_q + int'(step) : m_q - int'(step);
            if (s >= int'(MOD)) begin
                if (sat) begin m_q = MOD - 1; m_s = 1'b1; end
                else begin m_q = s - MOD; m_w = 1'b1; end
            end else if (s < 0) begin
                if (sat) begin m_q = 0; m_s = 1'b1; end
                else begin m_q = s + MOD; m_w = 1'b1; end
            end else begin
                m_q = s;
            end
        end
    endtask

    function automatic logic [8:0] exp_vec();
        return {N'(m_q), m_w, m_s, m_l, (m_q == int'(MOD) - 1), (m_q == 0)};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {q, wrap, sat_hit, load_err, max_tick, min_tick};
    endfunction

    task automatic set_in(input logic c, input logic l, input logic e, input logic u,
                          input logic s, input int st, input int dv);
        @(negedge clk);
        syn_clr = c; load = l; en = e; up = u; sat = s;
        step = STEP_W'(st); d = N'(dv);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        syn_clr = 0; load = 0; en = 0; up = 0; sat = 0; step = '0; d = '0;
        model_reset();
        #3;
        n_checks++;
        if (obs_vec() !== 9'b0000_000_01) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs_vec(), 9'b0000_000_01);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        int eq;
        set_in(0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            eq = (i + 1) % 10;
            n_checks++;
            if (q !== N'(eq) || wrap !== (eq == 0) || max_tick !== (eq == 9)) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: got q=%0d wrap=%b max=%b want q=%0d wrap=%b max=%b",
                         i, q, wrap, max_tick, eq, (eq == 0), (eq == 9));
            end
        end
    endtask

    task automatic test_wrap_down();
        int exp_q[3] = '{4, 1, 8};
        set_in(0, 1, 0, 0, 0, 0, 7);
        tick();
        n_checks++;
        if (q !== 4'd7) begin
            n_fail++;
            $display("FAIL down_load: got q=%0d want 7", q);
        end
        set_in(0, 0, 1, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== N'(exp_q[i]) || wrap !== (i == 2) || min_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_down[%0d]: got q=%0d wrap=%b min=%b want q=%0d wrap=%b min=0",
                         i, q, wrap, min_tick, exp_q[i], (i == 2));
            end
        end
    endtask

    task automatic test_sat_up();
        set_in(0, 1, 0, 0, 0, 0, 8);
        tick();
        set_in(0, 0, 1, 1, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (q !== 4'd9 || sat_hit !== 1'b1 || wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_up[%0d]: got q=%0d sat_hit=%b wrap=%b want q=9 sat_hit=1 wrap=0",
                         i, q, sat_hit, wrap);
            end
        end
    endtask

    task automatic test_load_err();
        set_in(0, 1, 0, 0, 0, 0, 12);
        tick();
        n_checks++;
        if (q !== 4'd9 || load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL load_oob: got q=%0d load_err=%b want q=9 load_err=1", q, load_err);
        end
        set_in(0, 1, 0, 0, 0, 0, 5);
        tick();
        n_checks++;
        if (q !== 4'd5 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ok: got q=%0d load_err=%b want q=5 load_err=0", q, load_err);
        end
    endtask

    task automatic test_priority();
        set_in(1, 1, 1, 1, 0, 1, 6);
        tick();
        n_checks++;
        if (q !== 4'd0) begin
            n_fail++;
            $display("FAIL prio_clr: got q=%0d want 0", q);
        end
        set_in(0, 1, 1, 1, 0, 1, 6);
        tick();
        n_checks++;
        if (q !== 4'd6) begin
            n_fail++;
            $display("FAIL prio_load: got q=%0d want 6", q);
        end
        set_in(0, 0, 1, 1, 0, 0, 0);
        tick();
        n_checks++;
        if ({q, wrap, sat_hit, load_err} !== {4'd6, 3'b000}) begin
            n_fail++;
            $display("FAIL step_zero: got q=%0d pulses=%b want q=6 pulses=000",
                     q, {wrap, sat_hit, load_err});
        end
    endtask

    task automatic test_async_reset();
        set_in(0, 1, 0, 0, 0, 0, 5);
        tick();
        set_in(0, 0, 1, 0, 0, 1, 0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 9'b0000_000_01) begin
            n_fail++;
            $display("FAIL async_reset: got %b want %b", obs_vec(), 9'b0000_000_01);
        end
        #0.5;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (q !== 4'd9 || wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL resume: got q=%0d wrap=%b want q=9 wrap=1", q, wrap);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(15) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                   1'($urandom), 1'($urandom), int'($urandom_range(3)), int'($urandom_range(15)));
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got %b want %b", i, obs_vec(), exp_vec());
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_sat_up();
        test_load_err();
        test_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
